// File: rtl/axxa_frame_tx_pkg.sv
// Shared types and constants for the a-x-x-a frame transmitter.
// The state encoding is fixed so that debug dumps read the same across the link.
package axxa_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4,
        GAPW = 3'd5
    } state_e;

    localparam int unsigned GAP_MAX   = 15;
    localparam int unsigned FRAME_LEN = 4;

    // Marker bit brackets the payload: {a, mid[1], mid[0], a}, MSB sent first.
    function automatic logic [FRAME_LEN-1:0] frame_word(logic a, logic [1:0] mid);
        return {a, mid, a};
    endfunction

endpackage

// File: rtl/axxa_frame_tx_if.sv
// Start/ready request and serial-output bundle of the a-x-x-a transmitter.
// master is the requesting side, slave is the transmitter.
interface axxa_frame_tx_if #(
    parameter int unsigned FRAMES_W = 8
);
    logic                start;
    logic                a;
    logic [1:0]          mid;
    logic                ready;
    logic                x;
    logic                x_vld;
    logic                frame_end;
    logic [FRAMES_W-1:0] frame_cnt;

    modport master (
        output start, a, mid,
        input  ready, x, x_vld, frame_end, frame_cnt
    );

    modport slave (
        input  start, a, mid,
        output ready, x, x_vld, frame_end, frame_cnt
    );
endinterface

// File: rtl/axxa_frame_tx_piso.sv
// 4-bit parallel-load, serial-out shifter, MSB first.
// nxt_o is the bit that will be on the line after the coming edge.
module axxa_piso
    import axxa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [FRAME_LEN-1:0] data_i,
    output logic                 nxt_o
);

    logic [FRAME_LEN-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            sreg_d = {sreg_q[FRAME_LEN-2:0], 1'b0};
        end
    end

    // sreg_q[MSB] is already on the line, so the following bit is one below it.
    assign nxt_o = load_i ? data_i[FRAME_LEN-1] : sreg_q[FRAME_LEN-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/axxa_frame_tx.sv
// Serial transmitter for a-x-x-a frames: accepts {a, mid} on start/ready and
// shifts out a, mid[1], mid[0], a one bit per clock, with optional idle gap.
module axxa_frame_tx
    import axxa_pkg::*;
#(
    parameter int unsigned FRAMES_W = 8,
    parameter int unsigned GAP      = 0,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    axxa_frame_tx_if.slave  tx
);

    localparam logic [3:0] GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_e              state_q, state_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [FRAMES_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                x_q, x_d;
    logic                x_vld_q, x_vld_d;
    logic                frame_end_q, frame_end_d;
    logic                ready;
    logic                accept;
    logic                piso_nxt;

    // Moore decode of the current state only; reset forces it low.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            B3:      ready = (GAP == 0);
            GAPW:    ready = (gap_cnt_q == GapLast);
            default: ready = 1'b0;
        endcase
        if (rst) begin
            ready = 1'b0;
        end
    end

    assign accept = tx.start & ready;

    axxa_piso u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (state_q inside {B0, B1, B2}),
        .data_i  (frame_word(tx.a, tx.mid)),
        .nxt_o   (piso_nxt)
    );

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: if (accept) state_d = B0;
            B0:   state_d = B1;
            B1:   state_d = B2;
            B2:   state_d = B3;
            B3: begin
                frame_cnt_d = frame_cnt_q + FRAMES_W'(1);
                if (GAP == 0) begin
                    state_d = accept ? B0 : IDLE;
                end else begin
                    state_d   = GAPW;
                    gap_cnt_d = '0;
                end
            end
            GAPW: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = accept ? B0 : IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        x_vld_d     = state_d inside {B0, B1, B2, B3};
        x_d         = x_vld_d ? piso_nxt : IDLE_BIT;
        frame_end_d = (state_d == B3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            x_q         <= IDLE_BIT;
            x_vld_q     <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            x_q         <= x_d;
            x_vld_q     <= x_vld_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign tx.ready     = ready;
    assign tx.x         = x_q;
    assign tx.x_vld     = x_vld_q;
    assign tx.frame_end = frame_end_q;
    assign tx.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axxa_frame_tx.sv
// Bench for axxa_frame_tx: three configurations tracked by a frame-position
// model every cycle, plus table-driven and hand-written directed sequences.
module tb_axxa_frame_tx;
    import axxa_pkg::*;

    localparam int unsigned GapA = 0;
    localparam int unsigned GapB = 3;
    localparam int unsigned GapC = 0;
    localparam int unsigned WA   = 8;
    localparam int unsigned WB   = 8;
    localparam int unsigned WC   = 2;

    if (GapB > GAP_MAX) begin : g_gap_range
        $error("GAP above GAP_MAX is illegal");
    end

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axxa_frame_tx_if #(.FRAMES_W(WA)) if0 ();
    axxa_frame_tx_if #(.FRAMES_W(WB)) if1 ();
    axxa_frame_tx_if #(.FRAMES_W(WC)) if2 ();

    axxa_frame_tx #(.FRAMES_W(WA), .GAP(GapA), .IDLE_BIT(1'b0)) u_dut0 (
        .clk (clk), .rst (rst), .tx (if0)
    );
    axxa_frame_tx #(.FRAMES_W(WB), .GAP(GapB), .IDLE_BIT(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .tx (if1)
    );
    axxa_frame_tx #(.FRAMES_W(WC), .GAP(GapC), .IDLE_BIT(1'b0)) u_dut2 (
        .clk (clk), .rst (rst), .tx (if2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = -1 idle, 0..3 frame bit index, 4..3+gap gap cycles.
    typedef struct {
        int          pos;
        logic [3:0]  word;
        int unsigned cnt;
    } mdl_t;

    function automatic mdl_t mdl_rst();
        mdl_t m;
        m.pos  = -1;
        m.word = 4'd0;
        m.cnt  = 0;
        return m;
    endfunction

    function automatic logic mdl_ready(mdl_t m, int gap, logic r);
        if (r) return 1'b0;
        return (m.pos == -1) || (m.pos == 3 + gap);
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int gap, logic start, logic a, logic [1:0] mid);
        mdl_t n;
        logic acc;
        n   = m;
        acc = start && mdl_ready(m, gap, 1'b0);
        if (m.pos == 3) n.cnt = m.cnt + 1;
        if (m.pos >= 0) begin
            n.pos = m.pos + 1;
            if (n.pos >= 4 + gap) n.pos = -1;
        end
        if (acc) begin
            n.pos  = 0;
            n.word = {a, mid[1], mid[0], a};
        end
        return n;
    endfunction

    function automatic logic mdl_x(mdl_t m, logic idle);
        if (m.pos >= 0 && m.pos <= 3) return m.word[3 - m.pos];
        return idle;
    endfunction

    mdl_t m0, m1, m2;
    logic chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mdl_rst();
            m1 <= mdl_rst();
            m2 <= mdl_rst();
        end else begin
            m0 <= mdl_step(m0, GapA, if0.start, if0.a, if0.mid);
            m1 <= mdl_step(m1, GapB, if1.start, if1.a, if1.mid);
            m2 <= mdl_step(m2, GapC, if2.start, if2.a, if2.mid);
        end
    end

    task automatic check_dut(input string tag, input mdl_t m, input int gap, input logic idle,
                             input int w, input logic rdy, input logic x, input logic vld,
                             input logic fe, input int cnt);
        chk({tag, ".ready"}, int'(rdy), int'(mdl_ready(m, gap, rst)));
        chk({tag, ".x"}, int'(x), int'(mdl_x(m, idle)));
        chk({tag, ".x_vld"}, int'(vld), int'(m.pos >= 0 && m.pos <= 3));
        chk({tag, ".frame_end"}, int'(fe), int'(m.pos == 3));
        chk({tag, ".frame_cnt"}, cnt, int'(m.cnt % (32'd1 << w)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("m0", m0, GapA, 1'b0, WA, if0.ready, if0.x, if0.x_vld, if0.frame_end,
                      int'(if0.frame_cnt));
            check_dut("m1", m1, GapB, 1'b1, WB, if1.ready, if1.x, if1.x_vld, if1.frame_end,
                      int'(if1.frame_cnt));
            check_dut("m2", m2, GapC, 1'b0, WC, if2.ready, if2.x, if2.x_vld, if2.frame_end,
                      int'(if2.frame_cnt));
        end
    end

    typedef struct {
        logic       a;
        logic [1:0] mid;
        logic [3:0] bits;
    } vec_t;

    vec_t vecs[5];
    bit   t3_x[8]   = '{1, 0, 1, 1, 1, 1, 1, 0};
    bit   t3_v[8]   = '{1, 1, 1, 1, 0, 0, 0, 1};
    bit   t3_r[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
    bit   t2_x[8]   = '{0, 1, 1, 0, 1, 0, 0, 1};
    int   t6_cnt[5] = '{1, 2, 3, 0, 1};

    task automatic idle_inputs();
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
    endtask

    // Ends on a negedge with rst low; edges of rst sit off the negedge.
    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{a: 1'b1, mid: 2'b01, bits: 4'b1011};
        vecs[1] = '{a: 1'b0, mid: 2'b11, bits: 4'b0110};
        vecs[2] = '{a: 1'b1, mid: 2'b10, bits: 4'b1101};
        vecs[3] = '{a: 1'b0, mid: 2'b00, bits: 4'b0000};
        vecs[4] = '{a: 1'b1, mid: 2'b11, bits: 4'b1111};

        if0.a = 1'b0; if0.mid = 2'b00;
        if1.a = 1'b0; if1.mid = 2'b00;
        if2.a = 1'b0; if2.mid = 2'b00;
        idle_inputs();
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst.ready", int'(if0.ready), 0);
        chk("rst.x_vld", int'(if0.x_vld), 0);
        chk("rst.x_idle1", int'(if1.x), 1);
        chk("rst.cnt", int'(if0.frame_cnt), 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("idle.ready", int'(if0.ready), 1);

        // Single frames from the vector table.
        foreach (vecs[i]) begin
            if0.start = 1'b1; if0.a = vecs[i].a; if0.mid = vecs[i].mid;
            @(negedge clk);
            if0.start = 1'b0;
            for (int b = 0; b < 4; b++) begin
                chk("tbl.x", int'(if0.x), int'(vecs[i].bits[3 - b]));
                chk("tbl.x_vld", int'(if0.x_vld), 1);
                chk("tbl.frame_end", int'(if0.frame_end), int'(b == 3));
                @(negedge clk);
            end
            chk("tbl.x_vld_after", int'(if0.x_vld), 0);
            chk("tbl.cnt", int'(if0.frame_cnt), i + 1);
        end

        // Back-to-back with no gap.
        do_reset();
        if0.start = 1'b1; if0.a = 1'b0; if0.mid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin if0.a = 1'b1; if0.mid = 2'b00; end
            if (k == 4) if0.start = 1'b0;
            chk("b2b.x", int'(if0.x), int'(t2_x[k]));
            chk("b2b.x_vld", int'(if0.x_vld), 1);
        end
        @(negedge clk);
        chk("b2b.cnt", int'(if0.frame_cnt), 2);

        // GAP=3 with start held.
        do_reset();
        if1.start = 1'b1; if1.a = 1'b1; if1.mid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin if1.a = 1'b0; if1.mid = 2'b10; end
            chk("gap.x", int'(if1.x), int'(t3_x[k]));
            chk("gap.x_vld", int'(if1.x_vld), int'(t3_v[k]));
            chk("gap.ready", int'(if1.ready), int'(t3_r[k]));
        end
        if1.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("gap.cnt", int'(if1.frame_cnt), 2);

        // Inputs changed after accept, start while busy dropped.
        do_reset();
        if0.start = 1'b1; if0.a = 1'b1; if0.mid = 2'b10;
        @(negedge clk);
        if0.start = 1'b0;
        chk("hold.b0", int'(if0.x), 1);
        @(negedge clk);
        chk("hold.b1", int'(if0.x), 1);
        if0.a = 1'b0; if0.mid = 2'b01; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("hold.b2", int'(if0.x), 0);
        @(negedge clk);
        chk("hold.b3", int'(if0.x), 1);
        repeat (2) @(negedge clk);
        chk("hold.no_extra", int'(if0.x_vld), 0);
        chk("hold.cnt", int'(if0.frame_cnt), 1);

        // Asynchronous reset in B2.
        do_reset();
        if0.start = 1'b1; if0.a = 1'b0; if0.mid = 2'b01;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst.cnt_pre", int'(if0.frame_cnt), 1);
        if0.start = 1'b1; if0.a = 1'b1; if0.mid = 2'b11;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst.in_b2", int'(if0.x_vld), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.x_vld", int'(if0.x_vld), 0);
        chk("arst.x", int'(if0.x), 0);
        chk("arst.frame_end", int'(if0.frame_end), 0);
        chk("arst.cnt", int'(if0.frame_cnt), 0);
        chk("arst.ready", int'(if0.ready), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("arst.ready_rel", int'(if0.ready), 1);
        @(negedge clk);
        if0.start = 1'b1; if0.a = 1'b1; if0.mid = 2'b00;
        @(negedge clk);
        if0.start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("arst.post_x", int'(if0.x), int'(b == 0 || b == 3));
            @(negedge clk);
        end
        chk("arst.post_cnt", int'(if0.frame_cnt), 1);

        // Counter wrap with FRAMES_W=2.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if2.start = 1'b1; if2.a = i[0]; if2.mid = i[1:0];
            @(negedge clk);
            if2.start = 1'b0;
            repeat (4) @(negedge clk);
            chk("wrap.cnt", int'(if2.frame_cnt), t6_cnt[i]);
        end

        // Random traffic on all three against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if0.start = ($urandom_range(0, 3) != 0);
            if0.a = 1'($urandom); if0.mid = 2'($urandom);
            if1.start = ($urandom_range(0, 2) != 0);
            if1.a = 1'($urandom); if1.mid = 2'($urandom);
            if2.start = ($urandom_range(0, 1) != 0);
            if2.a = 1'($urandom); if2.mid = 2'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(negedge clk);
        end

        idle_inputs();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
